// File: rtl/pc_gen_bp_pkg.sv
// Shared next-PC op encodings and BTB helpers for the fetch PC generator.
package pc_gen_bp_pkg;

  typedef logic [1:0] npc_op_t;

  localparam npc_op_t NPC_PC4 = 2'b00;
  localparam npc_op_t NPC_BRN = 2'b01;
  localparam npc_op_t NPC_JMP = 2'b10;

  // Only branches and jumps train the BTB; 2'b11 behaves like PC4.
  function automatic logic op_trains(input npc_op_t op);
    return (op == NPC_BRN) || (op == NPC_JMP);
  endfunction

  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic up);
    if (up) begin
      return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    end
    return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/pc_gen_bp_btb.sv
// Direct-mapped branch target buffer: combinational lookup, one synchronous update port.
module pc_gen_bp_btb
  import pc_gen_bp_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [XLEN-1:2] rd_pc_i,
  output logic            rd_taken_o,
  output logic [XLEN-1:0] rd_target_o,
  input  logic            wr_en_i,
  input  logic [XLEN-1:2] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic [XLEN-1:0] wr_target_i
);

  localparam int unsigned IDX  = $clog2(DEPTH);
  localparam int unsigned TAGW = XLEN - IDX - 2;

  logic            valid_q  [DEPTH];
  logic [1:0]      ctr_q    [DEPTH];
  logic [TAGW-1:0] tag_q    [DEPTH];
  logic [XLEN-1:0] target_q [DEPTH];

  logic [IDX-1:0]  rd_idx, wr_idx;
  logic [TAGW-1:0] rd_tag, wr_tag;
  logic            rd_hit, wr_hit;

  assign rd_idx = rd_pc_i[IDX+1:2];
  assign rd_tag = rd_pc_i[XLEN-1:IDX+2];
  assign wr_idx = wr_pc_i[IDX+1:2];
  assign wr_tag = wr_pc_i[XLEN-1:IDX+2];

  assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_taken_o  = rd_hit && ctr_q[rd_idx][1];
  assign rd_target_o = target_q[rd_idx];

  assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= 2'b00;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], wr_taken_i);
      end else if (wr_taken_i) begin
        valid_q[wr_idx] <= 1'b1;
        ctr_q[wr_idx]   <= 2'b10;
      end
    end
  end

  // Tags and targets are not reset; any taken update (hit or allocate) rewrites both.
  always_ff @(posedge clk_i) begin
    if (!rst_i && wr_en_i && wr_taken_i) begin
      tag_q[wr_idx]    <= wr_tag;
      target_q[wr_idx] <= wr_target_i;
    end
  end

endmodule

// File: rtl/pc_gen_bp.sv
// Registered fetch-PC generator with BTB prediction and EX-resolved redirect/training.
module pc_gen_bp
  import pc_gen_bp_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter int unsigned     BTB_DEPTH = 16
) (
  input  logic            cpu_clk,
  input  logic            cpu_rst,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_npc,
  input  logic            ex_valid,
  input  logic [1:0]      ex_op,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_offset,
  input  logic            ex_br,
  input  logic            ex_osel,
  input  logic [XLEN-1:0] ex_pred_npc,
  output logic [XLEN-1:0] ex_pc4,
  output logic            redirect,
  output logic [31:0]     mispred_cnt
);

  localparam logic [XLEN-1:0] PC_INC = XLEN'(4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] act;
  logic [XLEN-1:0] btb_target;
  logic            btb_taken;
  logic            train_en, train_taken;
  logic [31:0]     mispred_cnt_q;

  assign pc          = pc_q;
  assign pred_taken  = btb_taken;
  assign pred_npc    = btb_taken ? btb_target : pc_q + PC_INC;
  assign ex_pc4      = ex_pc + PC_INC;
  assign mispred_cnt = mispred_cnt_q;

  always_comb begin
    act = ex_pc4;
    case (ex_op)
      NPC_BRN: if (ex_br) act = ex_pc + ex_offset;
      NPC_JMP: act = ex_osel ? ex_offset : ex_pc + ex_offset;
      default: ;
    endcase
  end

  assign redirect = ex_valid && (act != ex_pred_npc);

  // Redirect beats stall so a flushed fetch never lingers on the wrong path.
  always_comb begin
    pc_d = pred_npc;
    if (redirect) begin
      pc_d = act;
    end else if (stall) begin
      pc_d = pc_q;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      pc_q          <= RESET_PC;
      mispred_cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      if (redirect && (mispred_cnt_q != 32'hFFFF_FFFF)) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign train_en    = ex_valid && op_trains(ex_op);
  assign train_taken = (ex_op == NPC_JMP) || ((ex_op == NPC_BRN) && ex_br);

  pc_gen_bp_btb #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk_i       (cpu_clk),
    .rst_i       (cpu_rst),
    .rd_pc_i     (pc_q[XLEN-1:2]),
    .rd_taken_o  (btb_taken),
    .rd_target_o (btb_target),
    .wr_en_i     (train_en),
    .wr_pc_i     (ex_pc[XLEN-1:2]),
    .wr_taken_i  (train_taken),
    .wr_target_i (act)
  );

endmodule

// File: tb/tb_pc_gen_bp.sv
// Scoreboard bench for pc_gen_bp: stimulus queues expected values, a negedge monitor checks them.
module tb_pc_gen_bp;
  import pc_gen_bp_pkg::*;

  localparam int S_PC   = 0;
  localparam int S_PTK  = 1;
  localparam int S_PNPC = 2;
  localparam int S_RED  = 3;
  localparam int S_CNT  = 4;
  localparam int S_PC4  = 5;

  typedef struct {
    int          cyc;
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  logic        cpu_clk;
  logic        cpu_rst;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_npc;
  logic        ex_valid;
  logic [1:0]  ex_op;
  logic [31:0] ex_pc;
  logic [31:0] ex_offset;
  logic        ex_br;
  logic        ex_osel;
  logic [31:0] ex_pred_npc;
  logic [31:0] ex_pc4;
  logic        redirect;
  logic [31:0] mispred_cnt;

  exp_t        exp_q[$];
  int          cyc     = 0;
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_cnt = 32'd0;

  pc_gen_bp #(
    .XLEN      (32),
    .RESET_PC  (32'h0),
    .BTB_DEPTH (16)
  ) dut (
    .cpu_clk     (cpu_clk),
    .cpu_rst     (cpu_rst),
    .stall       (stall),
    .pc          (pc),
    .pred_taken  (pred_taken),
    .pred_npc    (pred_npc),
    .ex_valid    (ex_valid),
    .ex_op       (ex_op),
    .ex_pc       (ex_pc),
    .ex_offset   (ex_offset),
    .ex_br       (ex_br),
    .ex_osel     (ex_osel),
    .ex_pred_npc (ex_pred_npc),
    .ex_pc4      (ex_pc4),
    .redirect    (redirect),
    .mispred_cnt (mispred_cnt)
  );

  initial begin
    cpu_clk = 1'b0;
    forever #5 cpu_clk = ~cpu_clk;
  end

  always @(posedge cpu_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Monitor: every negedge, compare all expectations due this cycle.
  initial begin
    logic [31:0] act_v;
    forever begin
      @(negedge cpu_clk);
      for (int i = exp_q.size() - 1; i >= 0; i--) begin
        if (exp_q[i].cyc <= cyc) begin
          case (exp_q[i].sel)
            S_PC:    act_v = pc;
            S_PTK:   act_v = {31'd0, pred_taken};
            S_PNPC:  act_v = pred_npc;
            S_RED:   act_v = {31'd0, redirect};
            S_CNT:   act_v = mispred_cnt;
            default: act_v = ex_pc4;
          endcase
          n_tests++;
          if (exp_q[i].cyc != cyc) begin
            n_fail++;
            $display("FAIL %s: not sampled in cycle %0d", exp_q[i].name, exp_q[i].cyc);
          end else if (act_v !== exp_q[i].val) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     exp_q[i].name, act_v, exp_q[i].val, cyc);
          end
          exp_q.delete(i);
        end
      end
    end
  end

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic chk(input int dc, input string nm, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc  = cyc + dc;
    e.name = nm;
    e.sel  = sel;
    e.val  = v;
    exp_q.push_back(e);
  endtask

  // Present one resolved EX instruction for one cycle; act_exp is the hand-computed target.
  task automatic ex_issue(input string nm, input logic [1:0] op, input logic [31:0] epc,
                          input logic [31:0] off, input logic br, input logic osel,
                          input logic [31:0] pred, input logic red, input logic [31:0] act_exp);
    ex_valid    = 1'b1;
    ex_op       = op;
    ex_pc       = epc;
    ex_offset   = off;
    ex_br       = br;
    ex_osel     = osel;
    ex_pred_npc = pred;
    chk(0, {nm, "_redirect"}, S_RED, {31'd0, red});
    chk(0, {nm, "_pc4"}, S_PC4, epc + 32'd4);
    if (red) begin
      exp_cnt++;
      chk(1, {nm, "_pc"}, S_PC, act_exp);
      chk(1, {nm, "_cnt"}, S_CNT, exp_cnt);
    end
    step();
    ex_valid = 1'b0;
  endtask

  // Force fetch to addr through a mispredicted PC4 op (never trains the BTB).
  task automatic goto(input string nm, input logic [31:0] addr);
    ex_issue(nm, NPC_PC4, addr - 32'd4, 32'd0, 1'b0, 1'b0, addr + 32'd8, 1'b1, addr);
  endtask

  initial begin
    cpu_rst     = 1'b1;
    stall       = 1'b0;
    ex_valid    = 1'b0;
    ex_op       = NPC_PC4;
    ex_pc       = '0;
    ex_offset   = '0;
    ex_br       = 1'b0;
    ex_osel     = 1'b0;
    ex_pred_npc = '0;
    repeat (3) step();
    cpu_rst = 1'b0;

    // Reset values and stall.
    chk(0, "rst_pc", S_PC, 32'h0);
    chk(0, "rst_ptk", S_PTK, 32'd0);
    chk(0, "rst_pnpc", S_PNPC, 32'h4);
    chk(0, "rst_cnt", S_CNT, 32'd0);
    step();
    chk(0, "t1_pc4", S_PC, 32'h4);
    chk(0, "t1_ptk4", S_PTK, 32'd0);
    step();
    chk(0, "t1_pc8a", S_PC, 32'h8);
    stall = 1'b1;
    step();
    chk(0, "t1_pc8b", S_PC, 32'h8);
    chk(0, "t1_ptk8", S_PTK, 32'd0);
    step();
    chk(0, "t1_pc8c", S_PC, 32'h8);
    stall = 1'b0;
    step();
    chk(0, "t1_pc12", S_PC, 32'hC);
    chk(0, "t1_ptk12", S_PTK, 32'd0);
    stall = 1'b1;
    step();

    // First-time taken branch allocates with ctr=2.
    ex_issue("t2_brn", NPC_BRN, 32'h10, 32'h40, 1'b1, 1'b0, 32'h14, 1'b1, 32'h50);
    goto("t2_goto10", 32'h10);
    chk(0, "t2_ptk", S_PTK, 32'd1);
    chk(0, "t2_pnpc", S_PNPC, 32'h50);

    // Hysteresis: saturate at 3, then two not-taken to drop prediction.
    for (int i = 0; i < 3; i++) begin
      ex_issue("t3_tk", NPC_BRN, 32'h10, 32'h40, 1'b1, 1'b0, 32'h50, 1'b0, 32'h0);
    end
    ex_issue("t3_nt1", NPC_BRN, 32'h10, 32'h40, 1'b0, 1'b0, 32'h14, 1'b0, 32'h0);
    chk(0, "t3_ptk1", S_PTK, 32'd1);
    chk(0, "t3_pnpc1", S_PNPC, 32'h50);
    chk(0, "t3_pc_held", S_PC, 32'h10);
    ex_issue("t3_nt2", NPC_BRN, 32'h10, 32'h40, 1'b0, 1'b0, 32'h14, 1'b0, 32'h0);
    chk(0, "t3_ptk2", S_PTK, 32'd0);
    chk(0, "t3_pnpc2", S_PNPC, 32'h14);

    // jalr: absolute target.
    ex_issue("t4_jalr", NPC_JMP, 32'h30, 32'h200, 1'b0, 1'b1, 32'h34, 1'b1, 32'h200);
    goto("t4_goto30", 32'h30);
    chk(0, "t4_ptk", S_PTK, 32'd1);
    chk(0, "t4_pnpc", S_PNPC, 32'h200);

    // Redirect while stalled; aliasing write at index 12 while lookup reads the old entry.
    chk(0, "t5_ptk_old", S_PTK, 32'd1);
    chk(0, "t5_pnpc_old", S_PNPC, 32'h200);
    ex_issue("t5_alias", NPC_BRN, 32'h70, 32'h100, 1'b1, 1'b0, 32'h74, 1'b1, 32'h170);
    goto("t5_goto30", 32'h30);
    chk(0, "t5_ptk_evict", S_PTK, 32'd0);
    chk(0, "t5_pnpc_evict", S_PNPC, 32'h34);
    goto("t5_goto70", 32'h70);
    chk(0, "t5_ptk_new", S_PTK, 32'd1);
    chk(0, "t5_pnpc_new", S_PNPC, 32'h170);

    // ex_op 2'b11 acts as PC4: no redirect, no training.
    ex_issue("t5_op3", 2'b11, 32'h40, 32'h1000, 1'b1, 1'b1, 32'h44, 1'b0, 32'h0);
    chk(0, "t5_op3_pc", S_PC, 32'h70);
    goto("t5_goto40", 32'h40);
    chk(0, "t5_op3_ptk", S_PTK, 32'd0);

    // Mid-run reset overrides a pending redirect and training.
    cpu_rst     = 1'b1;
    ex_valid    = 1'b1;
    ex_op       = NPC_JMP;
    ex_pc       = 32'h80;
    ex_offset   = 32'h40;
    ex_br       = 1'b0;
    ex_osel     = 1'b0;
    ex_pred_npc = 32'h84;
    exp_cnt     = 32'd0;
    chk(1, "t6_pc", S_PC, 32'h0);
    chk(1, "t6_cnt", S_CNT, 32'd0);
    chk(1, "t6_ptk", S_PTK, 32'd0);
    chk(1, "t6_pnpc", S_PNPC, 32'h4);
    step();
    cpu_rst  = 1'b0;
    ex_valid = 1'b0;
    goto("t6_goto80", 32'h80);
    chk(0, "t6_ptk80", S_PTK, 32'd0);
    goto("t6_goto10", 32'h10);
    chk(0, "t6_ptk10", S_PTK, 32'd0);
    goto("t6_goto70", 32'h70);
    chk(0, "t6_ptk70", S_PTK, 32'd0);

    repeat (2) step();
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
